memory: RTL and testbench

Memory-access stage of the Orion five-stage RV32 pipeline, between execute and writeback. It accepts one `ex_mem_t` instruction at a time and runs loads and stores over a valid/ready data-memory port. It aligns store data and byte enables, and extracts and extends load data. Each completed instruction is presented to writeback as a one-cycle `mem_wb_t` pulse; ALU-only instructions pass through with one cycle of latency.

---
 rtl/orion_types.sv | 46 ++++
 rtl/memory_align.sv | 50 +++++
 rtl/memory.sv | 124 ++++++++++++
 tb/tb_memory.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/orion_types.sv
// Shared Orion pipeline types: register-file sizing, memory-stage operation
// encodings and the execute->memory and memory->writeback bundles.
package orion_types;

  localparam int XLEN        = 32;
  localparam int RF_IDX_BITS = 5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                   valid;
    logic [XLEN-1:0]        alu_result;
    logic [XLEN-1:0]        rs2_v;
    logic [RF_IDX_BITS-1:0] rd_s;
    logic                   rd_we;
    mem_op_e                mem_op;
    mem_size_e              mem_size;
    logic                   mem_unsigned;
    logic [XLEN-1:0]        debug;
  } ex_mem_t;

  typedef struct packed {
    logic                   valid;
    logic [RF_IDX_BITS-1:0] rd_s;
    logic                   rd_we;
    logic [XLEN-1:0]        rd_v;
    logic [XLEN-1:0]        debug;
  } mem_wb_t;

endpackage

// File: rtl/memory_align.sv
// Combinational lane handling for the memory stage: store byte enables and
// replicated write data, load byte/half extraction with extension, misalign check.
module mem_align
  import orion_types::*;
(
  input  logic [1:0]      offset_i,
  input  mem_size_e       size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = '0;
    load_o       = '0;
    misaligned_o = 1'b0;
    // Move the addressed lane down to bit 0 so byte and half share one path.
    shifted      = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      MEM_B: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{rs2_i[7:0]}};
        load_o  = unsigned_i ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        be_o         = 4'b0011 << offset_i;
        wdata_o      = {2{rs2_i[15:0]}};
        load_o       = unsigned_i ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
        misaligned_o = offset_i[0];
      end
      MEM_W: begin
        be_o         = 4'b1111;
        wdata_o      = rs2_i;
        load_o       = rdata_i;
        misaligned_o = |offset_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Orion memory-access stage: single-outstanding load/store FSM over a
// valid/ready data port, retiring one registered mem_wb pulse per instruction.
module memory
  import orion_types::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  ex_mem_t         ex_mem_i,
  output logic            ex_mem_ready_o,
  output logic            dmem_req_valid_o,
  input  logic            dmem_req_ready_i,
  output logic [XLEN-1:0] dmem_req_addr_o,
  output logic            dmem_req_we_o,
  output logic [3:0]      dmem_req_be_o,
  output logic [XLEN-1:0] dmem_req_wdata_o,
  input  logic            dmem_rsp_valid_i,
  input  logic [XLEN-1:0] dmem_rsp_rdata_i,
  output mem_wb_t         mem_wb_o,
  output logic            misaligned_o
);

  mem_state_e      state_q, state_d;
  mem_wb_t         wb_q, wb_d;
  logic            mis_q, mis_d;
  ex_mem_t         cap_q;
  logic            cap_en;
  logic            idle;
  logic [1:0]      al_offset;
  mem_size_e       al_size;
  logic [XLEN-1:0] load_v;
  logic            al_mis;

  assign idle = (state_q == ST_IDLE);

  // In IDLE the aligner judges the incoming op; afterwards it formats the captured one.
  assign al_offset = idle ? ex_mem_i.alu_result[1:0] : cap_q.alu_result[1:0];
  assign al_size   = idle ? ex_mem_i.mem_size : cap_q.mem_size;

  mem_align u_align (
    .offset_i     (al_offset),
    .size_i       (al_size),
    .unsigned_i   (cap_q.mem_unsigned),
    .rs2_i        (cap_q.rs2_v),
    .rdata_i      (dmem_rsp_rdata_i),
    .be_o         (dmem_req_be_o),
    .wdata_o      (dmem_req_wdata_o),
    .load_o       (load_v),
    .misaligned_o (al_mis)
  );

  assign ex_mem_ready_o   = idle;
  assign dmem_req_valid_o = (state_q == ST_REQ) & cap_q.valid;
  assign dmem_req_addr_o  = cap_q.alu_result;
  assign dmem_req_we_o    = (cap_q.mem_op == MEM_STORE);
  assign mem_wb_o         = wb_q;
  assign misaligned_o     = mis_q;

  always_comb begin
    state_d = state_q;
    wb_d    = '0;
    mis_d   = 1'b0;
    cap_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_mem_i.valid) begin
          wb_d.rd_s  = ex_mem_i.rd_s;
          wb_d.rd_v  = ex_mem_i.alu_result;
          wb_d.debug = ex_mem_i.debug;
          if (ex_mem_i.mem_op == MEM_NONE) begin
            wb_d.valid = 1'b1;
            wb_d.rd_we = ex_mem_i.rd_we;
          end else if (al_mis) begin
            wb_d.valid = 1'b1;
            mis_d      = 1'b1;
          end else begin
            cap_en  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready_i) begin
          if (cap_q.mem_op == MEM_STORE) begin
            wb_d.valid = 1'b1;
            wb_d.rd_s  = cap_q.rd_s;
            wb_d.debug = cap_q.debug;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_RSP;
          end
        end
      end
      ST_RSP: begin
        if (dmem_rsp_valid_i) begin
          wb_d.valid = 1'b1;
          wb_d.rd_s  = cap_q.rd_s;
          wb_d.rd_we = cap_q.rd_we;
          wb_d.rd_v  = load_v;
          wb_d.debug = cap_q.debug;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      wb_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
    end
  end

  // Capture register carries data only; its contents matter only outside IDLE.
  always_ff @(posedge clk_i) begin
    if (cap_en) cap_q <= ex_mem_i;
  end

endmodule

// File: tb/tb_memory.sv
// Bench for the Orion memory stage: table of ALU/load/store vectors driven
// in sequence, retirements matched against a FIFO scoreboard, plus a reset-abort case.
module tb_memory;
  import orion_types::*;

  logic        clk = 1'b0;
  logic        rst_i;
  ex_mem_t     ex_mem_i;
  logic        ex_mem_ready_o;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic [31:0] dmem_req_addr_o;
  logic        dmem_req_we_o;
  logic [3:0]  dmem_req_be_o;
  logic [31:0] dmem_req_wdata_o;
  logic        dmem_rsp_valid_i;
  logic [31:0] dmem_rsp_rdata_i;
  mem_wb_t     mem_wb_o;
  logic        misaligned_o;

  memory dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .ex_mem_i         (ex_mem_i),
    .ex_mem_ready_o   (ex_mem_ready_o),
    .dmem_req_valid_o (dmem_req_valid_o),
    .dmem_req_ready_i (dmem_req_ready_i),
    .dmem_req_addr_o  (dmem_req_addr_o),
    .dmem_req_we_o    (dmem_req_we_o),
    .dmem_req_be_o    (dmem_req_be_o),
    .dmem_req_wdata_o (dmem_req_wdata_o),
    .dmem_rsp_valid_i (dmem_rsp_valid_i),
    .dmem_rsp_rdata_i (dmem_rsp_rdata_i),
    .mem_wb_o         (mem_wb_o),
    .misaligned_o     (misaligned_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_op_e     op;
    mem_size_e   size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd_s;
    logic        rd_we;
    int          req_stall;
    int          rsp_stall;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd_v;
    logic        exp_rd_we;
    logic        exp_mis;
    logic        chk_v;
  } vec_t;

  typedef struct {
    logic [4:0]  rd_s;
    logic        rd_we;
    logic [31:0] rd_v;
    logic        chk_v;
    logic        mis;
    logic [31:0] debug;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[14];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(mem_op_e op, mem_size_e size, logic uns, logic [31:0] addr,
                              logic [31:0] rs2, logic [31:0] rdata, logic [4:0] rd_s,
                              logic rd_we, int req_stall, int rsp_stall, logic [3:0] exp_be,
                              logic [31:0] exp_wdata, logic [31:0] exp_rd_v, logic exp_rd_we,
                              logic exp_mis, logic chk_v);
    vec_t v;
    v.op = op; v.size = size; v.uns = uns; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.rd_s = rd_s; v.rd_we = rd_we; v.req_stall = req_stall; v.rsp_stall = rsp_stall;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_rd_v = exp_rd_v;
    v.exp_rd_we = exp_rd_we; v.exp_mis = exp_mis; v.chk_v = chk_v;
    return v;
  endfunction

  task automatic chk_req(input vec_t v);
    chk("req_valid", dmem_req_valid_o, 1'b1);
    chk("req_addr", dmem_req_addr_o, v.addr);
    chk("req_we", dmem_req_we_o, v.op == MEM_STORE);
    if (v.op == MEM_STORE) begin
      chk("req_be", dmem_req_be_o, v.exp_be);
      chk("req_wdata", dmem_req_wdata_o, v.exp_wdata);
    end
    chk("ready_busy", ex_mem_ready_o, 1'b0);
    chk("wb_quiet", mem_wb_o.valid, 1'b0);
  endtask

  // Called at a falling edge; returns at the falling edge where the retire is visible.
  task automatic run_vec(input vec_t v, input int idx);
    sb_t e;
    chk("ready_idle", ex_mem_ready_o, 1'b1);
    ex_mem_i.valid        = 1'b1;
    ex_mem_i.alu_result   = v.addr;
    ex_mem_i.rs2_v        = v.rs2;
    ex_mem_i.rd_s         = v.rd_s;
    ex_mem_i.rd_we        = v.rd_we;
    ex_mem_i.mem_op       = v.op;
    ex_mem_i.mem_size     = v.size;
    ex_mem_i.mem_unsigned = v.uns;
    ex_mem_i.debug        = 32'(idx) + 32'h100;
    e.rd_s = v.rd_s; e.rd_we = v.exp_rd_we; e.rd_v = v.exp_rd_v;
    e.chk_v = v.chk_v; e.mis = v.exp_mis; e.debug = 32'(idx) + 32'h100;
    sbq.push_back(e);
    @(negedge clk);
    ex_mem_i.valid = 1'b0;
    if (v.op == MEM_NONE || v.exp_mis) begin
      chk("wb_lat1", mem_wb_o.valid, 1'b1);
      chk("no_req", dmem_req_valid_o, 1'b0);
      chk("ready_keep", ex_mem_ready_o, 1'b1);
      return;
    end
    for (int s = 0; s < v.req_stall; s++) begin
      chk_req(v);
      @(negedge clk);
    end
    dmem_req_ready_i = 1'b1;
    chk_req(v);
    @(negedge clk);
    dmem_req_ready_i = 1'b0;
    if (v.op == MEM_STORE) begin
      chk("wb_after_hs", mem_wb_o.valid, 1'b1);
      return;
    end
    chk("req_dropped", dmem_req_valid_o, 1'b0);
    chk("wb_wait_rsp", mem_wb_o.valid, 1'b0);
    for (int s = 0; s < v.rsp_stall; s++) begin
      @(negedge clk);
      chk("wb_rsp_stall", mem_wb_o.valid, 1'b0);
    end
    dmem_rsp_valid_i = 1'b1;
    dmem_rsp_rdata_i = v.rdata;
    @(negedge clk);
    dmem_rsp_valid_i = 1'b0;
    dmem_rsp_rdata_i = $urandom;
    chk("wb_after_rsp", mem_wb_o.valid, 1'b1);
  endtask

  // Scoreboard: every retire pulse must match the oldest pending expectation.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        chk("mis_only_with_valid", misaligned_o & ~mem_wb_o.valid, 1'b0);
        if (mem_wb_o.valid) begin
          chk("wb_pending", sbq.size() > 0, 1'b1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("wb_rd_s", mem_wb_o.rd_s, e.rd_s);
            chk("wb_rd_we", mem_wb_o.rd_we, e.rd_we);
            chk("wb_debug", mem_wb_o.debug, e.debug);
            chk("wb_mis", misaligned_o, e.mis);
            if (e.chk_v) chk("wb_rd_v", mem_wb_o.rd_v, e.rd_v);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(MEM_NONE,  MEM_W, 0, 32'h1234, 0, 0, 5'd5, 1, 0, 0, 4'h0, 0, 32'h1234, 1, 0, 1);
    vecs[1]  = mk(MEM_NONE,  MEM_W, 0, 32'hFFFFFFFF, 0, 0, 5'd7, 1, 0, 0, 4'h0, 0, 32'hFFFFFFFF, 1, 0, 1);
    vecs[2]  = mk(MEM_STORE, MEM_B, 0, 32'h103, 32'hAABBCCDD, 0, 5'd0, 0, 3, 0, 4'b1000, 32'hDDDDDDDD, 0, 0, 0, 0);
    vecs[3]  = mk(MEM_STORE, MEM_H, 0, 32'h102, 32'h11223344, 0, 5'd0, 0, 0, 0, 4'b1100, 32'h33443344, 0, 0, 0, 0);
    vecs[4]  = mk(MEM_STORE, MEM_W, 0, 32'h100, 32'hCAFEBABE, 0, 5'd0, 0, 1, 0, 4'b1111, 32'hCAFEBABE, 0, 0, 0, 0);
    vecs[5]  = mk(MEM_STORE, MEM_B, 0, 32'h100, 32'h0000005A, 0, 5'd0, 0, 0, 0, 4'b0001, 32'h5A5A5A5A, 0, 0, 0, 0);
    vecs[6]  = mk(MEM_LOAD,  MEM_B, 0, 32'h102, 0, 32'h0080FF00, 5'd9, 1, 0, 0, 4'h0, 0, 32'hFFFFFF80, 1, 0, 1);
    vecs[7]  = mk(MEM_LOAD,  MEM_B, 1, 32'h102, 0, 32'h0080FF00, 5'd10, 1, 0, 0, 4'h0, 0, 32'h00000080, 1, 0, 1);
    vecs[8]  = mk(MEM_LOAD,  MEM_H, 0, 32'h102, 0, 32'h80010000, 5'd11, 1, 1, 1, 4'h0, 0, 32'hFFFF8001, 1, 0, 1);
    vecs[9]  = mk(MEM_LOAD,  MEM_W, 0, 32'h104, 0, 32'hDEADBEEF, 5'd12, 1, 0, 4, 4'h0, 0, 32'hDEADBEEF, 1, 0, 1);
    vecs[10] = mk(MEM_LOAD,  MEM_H, 1, 32'h100, 0, 32'h1234F00D, 5'd13, 1, 0, 0, 4'h0, 0, 32'h0000F00D, 1, 0, 1);
    vecs[11] = mk(MEM_LOAD,  MEM_B, 0, 32'h100, 0, 32'h0000007F, 5'd14, 1, 2, 0, 4'h0, 0, 32'h0000007F, 1, 0, 1);
    vecs[12] = mk(MEM_LOAD,  MEM_W, 0, 32'h101, 0, 0, 5'd15, 1, 0, 0, 4'h0, 0, 0, 0, 1, 0);
    vecs[13] = mk(MEM_STORE, MEM_H, 0, 32'h103, 32'h1, 0, 5'd0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0);

    rst_i            = 1'b0;
    ex_mem_i         = '0;
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b0;
    dmem_rsp_rdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ex_mem_ready_o, 1'b1);
    chk("rst_wb", mem_wb_o, '0);
    chk("rst_mis", misaligned_o, 1'b0);
    chk("rst_req", dmem_req_valid_o, 1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ex_mem_ready_o, 1'b1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);
    @(negedge clk);

    // Reset while awaiting load data, then a stale response after release.
    ex_mem_i.valid      = 1'b1;
    ex_mem_i.alu_result = 32'h108;
    ex_mem_i.mem_op     = MEM_LOAD;
    ex_mem_i.mem_size   = MEM_W;
    ex_mem_i.rd_we      = 1'b1;
    ex_mem_i.rd_s       = 5'd3;
    @(negedge clk);
    ex_mem_i.valid   = 1'b0;
    dmem_req_ready_i = 1'b1;
    @(negedge clk);
    dmem_req_ready_i = 1'b0;
    chk("rsp_state_busy", ex_mem_ready_o, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("abort_ready", ex_mem_ready_o, 1'b1);
    chk("abort_wb", mem_wb_o, '0);
    chk("abort_req", dmem_req_valid_o, 1'b0);
    chk("abort_mis", misaligned_o, 1'b0);
    @(negedge clk);
    rst_i            = 1'b1;
    @(negedge clk);
    dmem_rsp_valid_i = 1'b1;
    dmem_rsp_rdata_i = 32'h55AA55AA;
    @(negedge clk);
    dmem_rsp_valid_i = 1'b0;
    chk("stale_rsp_wb", mem_wb_o, '0);
    chk("stale_rsp_ready", ex_mem_ready_o, 1'b1);
    chk("stale_rsp_req", dmem_req_valid_o, 1'b0);
    @(negedge clk);
    chk("stale_rsp_wb2", mem_wb_o.valid, 1'b0);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
